// File: rtl/dmem_store_responder.sv
// Data-memory responder: word-addressed RAM fronted by a FIFO store buffer
// that drains one entry per cycle and forwards buffered stores to loads.
module dmem_store_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int SB_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        sb_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = $clog2(SB_ENTRIES);

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [PTR_W:0]        cnt_t;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    logic [31:0]           ram_q [DEPTH];
    idx_t                  sb_idx_q [SB_ENTRIES];
    logic [31:0]           sb_data_q [SB_ENTRIES];
    logic [SB_ENTRIES-1:0] sb_vld_q, sb_vld_d;
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    cnt_t                  count_q, count_d;

    logic full, empty, enq, deq;
    idx_t word_idx;
    ptr_t slot;
    logic unused_adr_bits;

    // Byte offset and bits above the RAM range are intentionally dropped.
    assign word_idx        = dataadr[DEPTH_LOG2+1:2];
    assign unused_adr_bits = ^{dataadr[31:DEPTH_LOG2+2], dataadr[1:0]};

    assign full     = (count_q == cnt_t'(SB_ENTRIES));
    assign empty    = (count_q == '0);
    assign enq      = memwrite && !full;
    assign deq      = !empty;
    assign stall    = memwrite && full;
    assign sb_empty = empty;

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        sb_vld_d = sb_vld_q;
        if (deq) begin
            sb_vld_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (enq) begin
            sb_vld_d[tail_q] = 1'b1;
            tail_d           = tail_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk entries oldest to youngest so the youngest match overrides.
    always_comb begin
        readdata = ram_q[word_idx];
        slot     = head_q;
        for (int i = 0; i < SB_ENTRIES; i++) begin
            slot = head_q + ptr_t'(i);
            if (sb_vld_q[slot] && (sb_idx_q[slot] == word_idx)) begin
                readdata = sb_data_q[slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            sb_vld_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            sb_vld_q <= sb_vld_d;
        end
    end

    // A reset edge suppresses the drain so undrained stores are discarded.
    always_ff @(posedge clk) begin
        if (enq) begin
            sb_idx_q[tail_q]  <= word_idx;
            sb_data_q[tail_q] <= writedata;
        end
        if (deq && !reset) begin
            ram_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
        end
    end
endmodule

// File: tb/tb_dmem_store_responder.sv
// Randomized bench for dmem_store_responder against a queue-based store-buffer model.
module tb_dmem_store_responder;
    localparam int DL = 6;
    localparam int SB = 4;
    localparam int NW = 1 << DL;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        sb_empty;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } entry_t;

    entry_t      sbq[$];
    logic [31:0] ram_m [NW];
    bit          known [NW];
    int          n_checks = 0;
    int          n_pass   = 0;

    dmem_store_responder #(.DEPTH_LOG2(DL), .SB_ENTRIES(SB)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .readdata(readdata), .stall(stall), .sb_empty(sb_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int widx(input logic [31:0] adr);
        return int'(adr[DL+1:2]);
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic mw, input logic rst, input logic [31:0] adr, input logic [31:0] wd);
        int          ix;
        bit          hit;
        bit          was_full;
        logic [31:0] exp_rd;
        entry_t      e;
        memwrite  = mw;
        reset     = rst;
        dataadr   = adr;
        writedata = wd;
        #1;
        ix     = widx(adr);
        hit    = 1'b0;
        exp_rd = ram_m[ix];
        foreach (sbq[i]) if (sbq[i].idx == ix) begin exp_rd = sbq[i].data; hit = 1'b1; end
        check_eq("stall", {31'b0, stall}, {31'b0, mw && (sbq.size() == SB)});
        check_eq("sb_empty", {31'b0, sb_empty}, {31'b0, sbq.size() == 0});
        if (hit || known[ix]) check_eq("readdata", readdata, exp_rd);
        @(posedge clk);
        if (rst) begin
            sbq.delete();
        end else begin
            was_full = (sbq.size() == SB);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                ram_m[e.idx] = e.data;
                known[e.idx] = 1'b1;
            end
            if (mw && !was_full) sbq.push_back('{ix, wd});
        end
        @(negedge clk);
    endtask

    task automatic idle_read(input logic [31:0] adr);
        step(1'b0, 1'b0, adr, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("reset_sb_empty", {31'b0, sb_empty}, 32'd1);
        check_eq("reset_stall", {31'b0, stall}, 32'd0);

        // Give every RAM word a known value.
        for (int w = 0; w < NW; w++) step(1'b1, 1'b0, 32'(w * 4), 32'hA5000000 | 32'(w));
        repeat (3) idle_read(32'h0);

        // Single store, forwarded then committed.
        step(1'b1, 1'b0, 32'd80, 32'hFFFFFFFA);
        check_eq("store80_fwd", readdata, 32'hFFFFFFFA);
        idle_read(32'd80);
        idle_read(32'd80);
        check_eq("store80_ram", readdata, 32'hFFFFFFFA);

        // Back-to-back stores to the same word.
        step(1'b1, 1'b0, 32'd84, 32'd1);
        step(1'b1, 1'b0, 32'd84, 32'd2);
        check_eq("same_word_young", readdata, 32'd2);
        repeat (3) idle_read(32'd84);
        check_eq("same_word_ram", readdata, 32'd2);

        // Consecutive stores to distinct words.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 32'(k * 4), 32'h1000 + 32'(k));
        repeat (2) idle_read(32'd8);

        // Aliasing and ignored byte offset.
        step(1'b1, 1'b0, 32'd336, 32'hCAFEF00D);
        idle_read(32'd80);
        check_eq("alias_read", readdata, 32'hCAFEF00D);
        step(1'b1, 1'b0, 32'd91, 32'h0BADBEEF);
        idle_read(32'd88);
        check_eq("byteoff_read", readdata, 32'h0BADBEEF);
        repeat (2) idle_read(32'd88);

        // Reset with a store still buffered: it must never reach the RAM.
        step(1'b1, 1'b0, 32'd100, 32'h77777777);
        step(1'b0, 1'b1, 32'd100, 32'h0);
        step(1'b1, 1'b0, 32'd100, 32'h0);
        step(1'b0, 1'b0, 32'd100, 32'h0);
        repeat (2) idle_read(32'd100);

        // Reads of untouched words while the buffer drains other words.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 32'(128 + k * 4), $urandom);
            idle_read(32'(200 + k * 4));
        end

        // Random traffic, including aliasing addresses and occasional resets.
        for (int k = 0; k < 600; k++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'd80 + 32'($urandom_range(0, 3))) : $urandom;
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 49) == 0), a, $urandom);
        end

        // Drain, then verify every word's final contents.
        repeat (SB + 2) idle_read(32'h0);
        for (int w = 0; w < NW; w++) idle_read(32'(w * 4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
